// File: rtl/spi_pkg.sv
// Shared SPI register-bank types and command-field constants.
package spi_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StRead,
    StWrite,
    StSkip
  } spi_state_e;

  localparam int unsigned RwBit  = 7;  // 1 = write, 0 = read
  localparam int unsigned AdrW   = 7;
  localparam int unsigned CmdLen = 8;

endpackage

// File: rtl/spi_reg_bank_if.sv
// SPI serial bus bundle; the external master drives sclk/cs/mosi.
interface spi_reg_bank_if;
  logic sclk;
  logic cs;
  logic mosi;
  logic miso;

  modport master (output sclk, output cs, output mosi, input miso);
  modport slave  (input sclk, input cs, input mosi, output miso);
endinterface

// File: rtl/spi_sync_edge.sv
// Three-flop synchroniser with edge detection on the second and third flops.
module spi_sync_edge #(
  parameter logic RstVal = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [2:0] sync_q;

  // Shift the asynchronous input through the synchroniser chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {3{RstVal}};
    end else begin
      sync_q <= {sync_q[1:0], din};
    end
  end

  assign level = sync_q[1];
  assign rise  = sync_q[1] & ~sync_q[2];
  assign fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 slave exposing NCH read ports and NCH write registers of NBIT bits.
module spi_reg_bank
  import spi_pkg::*;
#(
  parameter int unsigned NBIT     = 16,
  parameter int unsigned NCH      = 4,
  parameter int unsigned BASE_ADR = 1
) (
  input  logic                clk,
  input  logic                rst,
  spi_reg_bank_if.slave       spi,
  input  logic [NCH*NBIT-1:0] inport,
  output logic [NCH*NBIT-1:0] outport,
  output logic                wr_stb,
  output logic [3:0]          wr_ch
);

  localparam int unsigned CntW = 6;

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic unused_sync;

  spi_sync_edge #(.RstVal(1'b0)) u_sync_sclk (
    .clk   (clk),
    .rst   (rst),
    .din   (spi.sclk),
    .level (sclk_lvl),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  // cs resets to "selected" so a frame already in progress when reset
  // releases never looks like a fresh falling edge.
  spi_sync_edge #(.RstVal(1'b0)) u_sync_cs (
    .clk   (clk),
    .rst   (rst),
    .din   (spi.cs),
    .level (cs_lvl),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  spi_sync_edge #(.RstVal(1'b0)) u_sync_mosi (
    .clk   (clk),
    .rst   (rst),
    .din   (spi.mosi),
    .level (mosi_lvl),
    .rise  (mosi_rise),
    .fall  (mosi_fall)
  );

  assign unused_sync = ^{sclk_lvl, mosi_rise, mosi_fall};

  spi_state_e            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [NBIT-1:0]       shift_q, shift_d;
  logic [3:0]            ch_q, ch_d;
  logic                  load_q, load_d;
  logic                  miso_q, miso_d;
  logic [NCH*NBIT-1:0]   outport_q, outport_d;
  logic                  wr_stb_q, wr_stb_d;
  logic [3:0]            wr_ch_q, wr_ch_d;

  logic                  rise_en, fall_en;
  logic [CmdLen-1:0]     cmd;
  logic [AdrW-1:0]       adr;
  logic                  adr_hit;
  logic [3:0]            adr_ch;

  assign rise_en = sclk_rise & ~cs_lvl;
  assign fall_en = sclk_fall & ~cs_lvl;
  assign cmd     = {shift_q[CmdLen-2:0], mosi_lvl};
  assign adr     = cmd[AdrW-1:0];
  assign adr_hit = ({1'b0, adr} >= 8'(BASE_ADR)) && ({1'b0, adr} < 8'(BASE_ADR + NCH));
  assign adr_ch  = 4'(adr - 7'(BASE_ADR));

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shift_q   <= '0;
      ch_q      <= '0;
      load_q    <= 1'b0;
      miso_q    <= 1'b1;
      outport_q <= '0;
      wr_stb_q  <= 1'b0;
      wr_ch_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      ch_q      <= ch_d;
      load_q    <= load_d;
      miso_q    <= miso_d;
      outport_q <= outport_d;
      wr_stb_q  <= wr_stb_d;
      wr_ch_q   <= wr_ch_d;
    end
  end

  // Frame sequencing, shifting and register update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    ch_d      = ch_q;
    load_d    = load_q;
    miso_d    = miso_q;
    outport_d = outport_q;
    wr_stb_d  = 1'b0;
    wr_ch_d   = wr_ch_q;

    unique case (state_q)
      StIdle: begin
        if (cs_fall) begin
          state_d = StCmd;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      StCmd: begin
        if (rise_en) begin
          shift_d = {shift_q[NBIT-2:0], mosi_lvl};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CntW'(CmdLen - 1)) begin
            cnt_d = '0;
            if (adr_hit) begin
              ch_d = adr_ch;
              if (cmd[RwBit]) begin
                state_d = StWrite;
              end else begin
                state_d = StRead;
                load_d  = 1'b1;
              end
            end else begin
              state_d = StSkip;
            end
          end
        end
      end
      StRead: begin
        if (load_q) begin
          // Snapshot taken once; later inport changes do not affect this frame.
          load_d = 1'b0;
          for (int k = 0; k < NCH; k++) begin
            if (ch_q == 4'(k)) shift_d = inport[k*NBIT +: NBIT];
          end
        end else if (fall_en && cnt_q != CntW'(NBIT)) begin
          miso_d  = shift_q[NBIT-1];
          shift_d = {shift_q[NBIT-2:0], 1'b0};
          cnt_d   = cnt_q + 1'b1;
        end else if (rise_en && cnt_q == CntW'(NBIT)) begin
          // Hold the last bit until the master has sampled it.
          state_d = StSkip;
        end
      end
      StWrite: begin
        if (rise_en) begin
          shift_d = {shift_q[NBIT-2:0], mosi_lvl};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CntW'(NBIT - 1)) begin
            for (int k = 0; k < NCH; k++) begin
              if (ch_q == 4'(k)) outport_d[k*NBIT +: NBIT] = {shift_q[NBIT-2:0], mosi_lvl};
            end
            wr_stb_d = 1'b1;
            wr_ch_d  = ch_q;
            state_d  = StSkip;
          end
        end
      end
      StSkip: begin
      end
      default: state_d = StIdle;
    endcase

    if (cs_rise) begin
      state_d = StIdle;
      load_d  = 1'b0;
    end

    if (state_d != StRead) miso_d = 1'b1;
  end

  assign spi.miso = miso_q;
  assign outport  = outport_q;
  assign wr_stb   = wr_stb_q;
  assign wr_ch    = wr_ch_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Scoreboard bench for spi_reg_bank: stimulus queues expected frames/writes,
// independent monitors compare them as the DUT responds.
module tb_spi_reg_bank;

  localparam int unsigned NBIT     = 16;
  localparam int unsigned NCH      = 4;
  localparam int unsigned BASE_ADR = 1;

  logic                clk = 1'b0;
  logic                rst;
  logic [NCH*NBIT-1:0] inport;
  logic [NCH*NBIT-1:0] outport;
  logic                wr_stb;
  logic [3:0]          wr_ch;

  spi_reg_bank_if spi ();

  always #5 clk = ~clk;

  spi_reg_bank #(
    .NBIT     (NBIT),
    .NCH      (NCH),
    .BASE_ADR (BASE_ADR)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .spi     (spi),
    .inport  (inport),
    .outport (outport),
    .wr_stb  (wr_stb),
    .wr_ch   (wr_ch)
  );

  typedef struct {
    string       name;
    int          n;
    logic [63:0] bits;
  } frame_t;

  typedef struct {
    logic [3:0]  ch;
    logic [15:0] data;
  } wr_t;

  frame_t      fq[$];
  wr_t         wq[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_pulses = 0;
  logic [63:0] cap;
  int          ncap;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Capture miso the way the master does: on each sclk rising edge.
  initial begin
    cap  = '0;
    ncap = 0;
    forever begin
      @(posedge spi.sclk);
      if (spi.cs === 1'b0) begin
        cap = {cap[62:0], spi.miso};
        ncap++;
      end
    end
  end

  // End of frame: compare captured miso bits with the queued expectation.
  initial begin
    frame_t f;
    forever begin
      @(posedge spi.cs);
      if (ncap != 0) begin
        if (fq.size() == 0) begin
          check("frame_unexpected", 64'(ncap), 64'd0);
        end else begin
          f = fq.pop_front();
          check({f.name, "_len"}, 64'(ncap), 64'(f.n));
          check(f.name, cap, f.bits);
        end
        cap  = '0;
        ncap = 0;
      end
    end
  end

  // Write monitor: every wr_stb pulse must match a queued write.
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (wr_stb === 1'b1) begin
        n_pulses++;
        if (wq.size() == 0) begin
          check("wr_stb_unexpected", 64'(wr_stb), 64'd0);
        end else begin
          w = wq.pop_front();
          check("wr_ch", 64'(wr_ch), 64'(w.ch));
          check("wr_data", 64'(outport[w.ch*NBIT +: NBIT]), 64'(w.data));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic half();
    repeat (5) @(negedge clk);
  endtask

  task automatic cs_low();
    spi.cs = 1'b0;
    half();
  endtask

  task automatic cs_high();
    half();
    spi.cs = 1'b1;
    repeat (4) half();
  endtask

  task automatic shift_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      spi.mosi = v[i];
      half();
      spi.sclk = 1'b1;
      half();
      spi.sclk = 1'b0;
    end
  endtask

  task automatic push_frame(input string name, input int n, input logic [63:0] bits);
    frame_t f;
    f.name = name;
    f.n    = n;
    f.bits = bits;
    fq.push_back(f);
  endtask

  task automatic push_write(input logic [3:0] ch, input logic [15:0] data);
    wr_t w;
    w.ch   = ch;
    w.data = data;
    wq.push_back(w);
  endtask

  // Read frame: 8 command clocks + 16 data clocks + one extra that must see 1.
  task automatic read_frame(input string name, input logic [7:0] cmd, input logic [15:0] data);
    push_frame(name, 25, 64'({8'hFF, data, 1'b1}));
    cs_low();
    shift_bits(32'(cmd), 8);
    shift_bits(32'd0, 17);
    cs_high();
  endtask

  // Write-shaped frame: miso must stay high for all 24 clocks.
  task automatic write_frame(input string name, input logic [7:0] cmd, input logic [15:0] data);
    push_frame(name, 24, 64'h00FF_FFFF);
    cs_low();
    shift_bits(32'({cmd, data}), 24);
    cs_high();
  endtask

  initial begin
    spi.sclk = 1'b0;
    spi.cs   = 1'b1;
    spi.mosi = 1'b0;
    rst      = 1'b1;
    inport   = {16'hC3C3, 16'hA55A, 16'h2468, 16'h1357};
    repeat (3) @(negedge clk);
    check("rst_outport", outport, 64'd0);
    check("rst_wr_stb", 64'(wr_stb), 64'd0);
    check("rst_wr_ch", 64'(wr_ch), 64'd0);
    check("rst_miso", 64'(spi.miso), 64'd1);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    read_frame("read_ch2", 8'h03, 16'hA55A);

    // Reset while the 5th data bit (a 0) is on miso.
    push_frame("read_rst_abort", 16, 64'hFFAF);
    cs_low();
    shift_bits(32'h03, 8);
    shift_bits(32'd0, 4);
    half();
    check("miso_before_rst", 64'(spi.miso), 64'd0);
    rst = 1'b1;
    #1;
    check("miso_in_rst", 64'(spi.miso), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    shift_bits(32'd0, 4);
    cs_high();

    read_frame("read_after_rst", 8'h03, 16'hA55A);

    // inport changes mid-read; miso must follow the snapshot.
    push_frame("read_snapshot", 25, 64'({8'hFF, 16'hA55A, 1'b1}));
    cs_low();
    shift_bits(32'h03, 8);
    shift_bits(32'd0, 6);
    inport[47:32] = 16'h0F0F;
    shift_bits(32'd0, 11);
    cs_high();
    inport[47:32] = 16'hA55A;

    push_write(4'd1, 16'h1234);
    write_frame("write_ch1_miso", 8'h82, 16'h1234);
    check("outport_after_wr1", outport, 64'h0000_0000_1234_0000);
    push_write(4'd3, 16'hBEEF);
    write_frame("write_ch3_miso", 8'h84, 16'hBEEF);
    check("outport_after_wr2", outport, 64'hBEEF_0000_1234_0000);

    write_frame("unmapped_miso", 8'h05, 16'hFFFF);
    check("outport_after_unmapped", outport, 64'hBEEF_0000_1234_0000);

    // Write to ch0 aborted after 9 data bits.
    push_frame("partial_miso", 17, 64'h1_FFFF);
    cs_low();
    shift_bits(32'h81, 8);
    shift_bits(32'h155, 9);
    cs_high();
    check("outport_after_partial", outport, 64'hBEEF_0000_1234_0000);

    read_frame("read_ch0", 8'h01, 16'h1357);

    repeat (20) @(negedge clk);
    check("wr_pulse_count", 64'(n_pulses), 64'd2);
    check("write_queue_empty", 64'(wq.size()), 64'd0);
    check("frame_queue_empty", 64'(fq.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
